// File: rtl/uart_defs.sv
// Shared 8N1 UART definitions: frame constants and receiver/transmitter FSM states.
package uart_defs;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off a FSM-controlled down-counting bit timer.
module uart_rx
  import uart_defs::*;
#(
  parameter int unsigned FREQ = 50_000_000,
  parameter int unsigned RATE = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_vld,
  output logic                 o_frame_err
);

  localparam int unsigned DIV  = FREQ / RATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned TW   = $clog2(DIV);
  localparam int unsigned IW   = $clog2(DATA_BITS);

  if (DIV < 4) begin : g_div_too_small
    $error("uart_rx: FREQ/RATE must be at least 4");
  end

  logic                 w_rx;
  logic                 w_tick;
  uart_state_e          r_state,  w_state_nxt;
  logic [TW-1:0]        r_timer,  w_timer_nxt;
  logic [IW-1:0]        r_idx,    w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
  logic [DATA_BITS-1:0] r_data,   w_data_nxt;
  logic                 r_vld,    w_vld_nxt;
  logic                 r_ferr,   w_ferr_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_rx),
    .o_q   (w_rx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_vld   <= w_vld_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  assign w_tick = (r_timer == '0);

  // A sample is taken on the cycle the timer reaches zero; otherwise it counts down.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_vld_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx) begin
          w_state_nxt = ST_START;
          w_timer_nxt = TW'(HALF - 1);
        end
      end
      ST_START: begin
        if (!w_tick) begin
          w_timer_nxt = r_timer - 1'b1;
        end else if (w_rx) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = '0;
          w_timer_nxt = TW'(DIV - 1);
        end
      end
      ST_DATA: begin
        if (!w_tick) begin
          w_timer_nxt = r_timer - 1'b1;
        end else begin
          w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
          w_timer_nxt = TW'(DIV - 1);
          if (r_idx == IW'(DATA_BITS - 1)) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (!w_tick) begin
          w_timer_nxt = r_timer - 1'b1;
        end else if (w_rx) begin
          w_data_nxt  = r_shift;
          w_vld_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (w_rx) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign o_data      = r_data;
  assign o_vld       = r_vld;
  assign o_frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: behavioural 8N1 transmitter, expected-byte queue, strobe monitor.
module tb_uart_rx;

  localparam int unsigned DIV = 25;

  logic       clk;
  logic       rst_n;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_vld;
  logic       o_frame_err;

  uart_rx #(.FREQ(50_000_000), .RATE(2_000_000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_vld       (o_vld),
    .o_frame_err (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int ferr_cnt     = 0;
  int both_cnt     = 0;
  int long_cnt     = 0;
  int unstable_cnt = 0;
  logic       prev_vld  = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Observe strobes and o_data stability away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_vld) got_q.push_back(o_data);
      if (o_frame_err) ferr_cnt++;
      if (o_vld && o_frame_err) both_cnt++;
      if ((o_vld && prev_vld) || (o_frame_err && prev_ferr)) long_cnt++;
      if (!o_vld && (o_data !== prev_data)) unstable_cnt++;
    end
    prev_vld  = o_vld;
    prev_ferr = o_frame_err;
    prev_data = o_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
    i_rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (per) @(negedge clk);
    end
    i_rx = stop;
    repeat (per) @(negedge clk);
  endtask

  // Compare everything received since the last call with the model's expectation.
  task automatic check_rx(input string tag, input int exp_ferr);
    logic [7:0] obs;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      obs = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      chk({tag, "_data"}, 32'(obs), 32'(exp_q.pop_front()));
    end
    chk({tag, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
    got_q.delete();
    ferr_cnt = 0;
  endtask

  initial begin
    logic [7:0] b;
    int per;
    i_rx  = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data", 32'(o_data), 32'h00);
    chk("rst_vld", 32'(o_vld), 32'h0);
    chk("rst_ferr", 32'(o_frame_err), 32'h0);
    rst_n = 1'b1;
    idle(10);

    // Loopback 0x30..0x3F, back-to-back.
    for (int i = 0; i < 16; i++) begin
      b = 8'h30 + 8'(i);
      exp_q.push_back(b);
      send_frame(b, DIV, 1'b1);
    end
    idle(40);
    check_rx("loop", 0);

    // Short low glitch, then a real frame.
    i_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(60);
    check_rx("glitch", 0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, DIV, 1'b1);
    idle(40);
    check_rx("after_glitch", 0);

    // Bad stop bit with the line held low afterwards.
    send_frame(8'h3C, DIV, 1'b0);
    repeat (100) @(negedge clk);
    check_rx("frame_err", 1);
    chk("frame_err_data_kept", 32'(o_data), 32'hA5);
    idle(30);
    check_rx("break_release", 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, DIV, 1'b1);
    idle(40);
    check_rx("after_break", 0);

    // Reset pulse in the middle of data bit 3 of 0xFF.
    i_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    i_rx = 1'b1;
    repeat (3 * DIV + 12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_data", 32'(o_data), 32'h00);
    chk("midrst_vld", 32'(o_vld), 32'h0);
    chk("midrst_ferr", 32'(o_frame_err), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6 * DIV);
    check_rx("midrst_nostrobe", 0);
    chk("midrst_data_hold", 32'(o_data), 32'h00);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, DIV, 1'b1);
    idle(40);
    check_rx("after_rst", 0);

    // Transmitter slightly slow then slightly fast, back-to-back.
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, 24, 1'b1);
    send_frame(8'hAA, 26, 1'b1);
    idle(40);
    check_rx("baud_tol", 0);

    // Random bytes at random in-tolerance bit periods and random gaps.
    for (int i = 0; i < 12; i++) begin
      b   = 8'($urandom_range(255, 0));
      per = int'($urandom_range(26, 24));
      exp_q.push_back(b);
      send_frame(b, per, 1'b1);
      idle(int'($urandom_range(10, 0)));
    end
    idle(40);
    check_rx("random", 0);

    chk("vld_and_ferr_same_cycle", 32'(both_cnt), 32'd0);
    chk("strobe_width", 32'(long_cnt), 32'd0);
    chk("data_stable", 32'(unstable_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FREQ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter RATE, default 2_000_000, meaning line bit rate in baud.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port i_rx, input, 1, asynchronous serial line that idles high.
REQ-006 SHALL have port o_data, output, 8, last correctly received byte.
REQ-007 SHALL have port o_vld, output, 1, one-cycle strobe marking o_data as new.
REQ-008 SHALL have port o_frame_err, output, 1, one-cycle strobe on a bad stop bit.

Function
REQ-009 SHALL use frame format 8N1: start bit 0, data bits LSB first, stop bit 1, no parity.
REQ-010 SHALL compute DIV = FREQ/RATE with integer truncation, and HALF = DIV/2.
- Elaboration SHALL fail if DIV < 4.
REQ-011 SHALL pass i_rx through a 2-flop synchronizer reset to 1; "rx" below means the synchronized value.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK; the reset state is IDLE.
REQ-013 SHALL, in IDLE with rx==0, go to START and load the bit-timer so the next sample falls HALF cycles later.
REQ-014 SHALL, on the START mid-bit sample:
- rx==1: treat as a glitch and return to IDLE with no strobe.
- rx==0: go to DATA with bit index 0.
REQ-015 SHALL, in DATA, sample rx every DIV cycles into a shift register (LSB first).
- After bit index 7 is sampled, go to STOP.
REQ-016 SHALL, in STOP, sample rx DIV cycles after the last data sample.
- rx==1: update o_data, pulse o_vld on the next cycle, return to IDLE.
- rx==0: pulse o_frame_err on the next cycle, leave o_data unchanged, enter BREAK.
REQ-017 SHALL stay in BREAK until rx==1, then go to IDLE; a line held low never produces o_vld.
REQ-018 SHALL never assert o_vld and o_frame_err in the same cycle; each strobe is exactly one cycle.
REQ-019 SHALL hold o_data stable between o_vld strobes.
REQ-020 SHALL accept a new start bit in the cycle immediately after returning to IDLE from STOP, so back-to-back frames with a single stop bit are received.
REQ-021 SHALL keep the bit-timer width at $clog2(DIV) bits; the timer SHALL wrap/reload only under FSM control and never free-run.
REQ-022 SHALL have a latency from the stop-bit mid-point on i_rx to o_vld of at most 2 sync cycles + 1 cycle.

Reset
REQ-023 SHALL, while rst_n==0, force o_data=8'h00, o_vld=0, o_frame_err=0, FSM=IDLE, timer=0, bit index=0, synchronizer=1.
REQ-024 SHALL, on reset asserted mid-frame, discard the partial byte with no strobe, and resume with the next start bit after release.

Structure
REQ-025 SHALL place the FSM state encodings and the 8N1 frame constants (data width 8, stop bits 1) in a shared uart_defs package/header that uart_tx also uses.
REQ-026 SHALL instantiate one sub-module, sync_2ff (1-bit, reset value parameter), for the input synchronizer.
REQ-027 SHALL contain the FSM, bit-timer and shift register directly in uart_rx.

Verification (FREQ=50_000_000, RATE=2_000_000, DIV=25)
REQ-028 Loopback: uart_tx sends 8'h30..8'h3F -> 16 o_vld strobes with matching o_data, in order; o_frame_err stays 0.
REQ-029 Glitch: i_rx low for 5 cycles, then high -> no o_vld and no o_frame_err; a following frame 8'hA5 is received correctly.
REQ-030 Framing error: frame 8'h3C sent with stop bit 0 and the line held low for 100 cycles -> one o_frame_err pulse, no o_vld, o_data unchanged; after the line returns high, frame 8'h81 gives o_vld with o_data=8'h81.
REQ-031 Reset mid-frame: rst_n low for 3 cycles during data bit 3 of 8'hFF -> outputs 0 immediately, no strobe; the next frame 8'h5A gives o_data=8'h5A.
REQ-032 Baud tolerance: the transmitter bit period is 24 then 26 cycles, sending 8'h55 and 8'hAA back-to-back -> both bytes are received correctly.
